mem_arbiter_rr: RTL

//  Parametrised round-robin arbiter granting CORE_NUM cores access to one single-port RAM.

---
 rtl/mem_arbiter_rr.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port RAM between CORE_NUM cores.
// One transaction at a time; each completion is signalled by a one-cycle response pulse.
module mem_arbiter_rr #(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int CORE_NUM    = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CORE_NUM-1:0]            request,
    input  logic [CORE_NUM-1:0]            wren_core,
    input  logic [CORE_NUM*ADDR_WIDTH-1:0] address_in,
    input  logic [CORE_NUM*WIDTH-1:0]      data_in,
    output logic [CORE_NUM*WIDTH-1:0]      data_out,
    output logic [CORE_NUM-1:0]            response,
    output logic [ADDR_WIDTH-1:0]          address,
    output logic [WIDTH-1:0]               data_write,
    output logic                           wren,
    input  logic [WIDTH-1:0]               data_read,
    output logic                           busy,
    output logic [$clog2(CORE_NUM)-1:0]    grant_id
);

    localparam int ID_W  = $clog2(CORE_NUM);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(CORE_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [ID_W-1:0]      ptr;
    logic [CORE_NUM-1:0]  excl;
    logic [CORE_NUM-1:0]  mask;
    logic                 hi_found;
    logic                 lo_found;
    logic                 found;
    logic [ID_W-1:0]      hi_win;
    logic [ID_W-1:0]      lo_win;
    logic [ID_W-1:0]      win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WIDTH-1:0]     win_data;
    logic                 win_wren;

    assign mask = request & ~excl;
    assign busy = (state != IDLE);

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest one below ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int k = CORE_NUM - 1; k >= 0; k--) begin
            if (mask[k]) begin
                if (ID_W'(k) >= ptr) begin
                    hi_found = 1'b1;
                    hi_win   = ID_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_win   = ID_W'(k);
                end
            end
        end
        found = hi_found | lo_found;
        win   = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_wren = 1'b0;
        for (int k = 0; k < CORE_NUM; k++) begin
            if (win == ID_W'(k)) begin
                win_addr = address_in[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = data_in[k*WIDTH +: WIDTH];
                win_wren = wren_core[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = (MEM_LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == CNT_ONE) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // excl only ever lives for the IDLE cycle right after RESP, hiding a request the
    // just-served core has not dropped yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            ptr        <= '0;
            excl       <= '0;
            address    <= '0;
            data_write <= '0;
            wren       <= 1'b0;
            grant_id   <= '0;
            response   <= '0;
            data_out   <= '0;
        end else begin
            response <= '0;
            excl     <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        address  <= win_addr;
                        grant_id <= win;
                        wren     <= win_wren;
                        if (win_wren) begin
                            data_write <= win_data;
                        end
                        cnt <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                end
                RESP: begin
                    wren <= 1'b0;
                    ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
                    for (int k = 0; k < CORE_NUM; k++) begin
                        if (grant_id == ID_W'(k)) begin
                            data_out[k*WIDTH +: WIDTH] <= data_read;
                            response[k]                <= 1'b1;
                            excl[k]                    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
